// File: rtl/note_judge.sv
// Four-lane hit judge: press sync, per-lane IDLE/ZONE/HIT FSMs, score/combo/multiplier.
// Define NOTE_JUDGE_GHOST_PENALTY_EN to report stray presses on o_ghost and break the combo.
module note_lane #(
    parameter bit GHOST_EN = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       en,
    input  logic [1:0] st,
    input  logic       stb,
    input  logic       press,
    output logic       hit,
    output logic       miss,
    output logic       ghost
);
    typedef enum logic [1:0] {IDLE, ZONE, HIT} lane_t;
    lane_t cur, nxt;
    logic  bottom;

    assign bottom = stb && (st == 2'b10);

    always_ff @(posedge i_clk) begin
        if (i_rst) cur <= IDLE;
        else       cur <= nxt;
    end

    // hit/miss/ghost describe what happens at the coming edge
    always_comb begin
        nxt   = cur;
        hit   = 1'b0;
        miss  = 1'b0;
        ghost = 1'b0;
        if (!en) begin
            nxt = IDLE;
        end else begin
            case (cur)
                IDLE: begin
                    ghost = GHOST_EN && press;
                    if (bottom) miss = 1'b1;
                    else if (st == 2'b01) nxt = ZONE;
                end
                ZONE: begin
                    if (bottom) begin
                        miss = 1'b1;
                        nxt  = IDLE;
                    end else if (press) begin
                        hit = 1'b1;
                        nxt = HIT;
                    end else if (st == 2'b00) begin
                        nxt = IDLE;
                    end
                end
                HIT: begin
                    ghost = GHOST_EN && press;
                    if (bottom) nxt = IDLE;
                end
                default: nxt = IDLE;
            endcase
        end
    end
endmodule

module note_judge #(
    parameter int HIT_PTS    = 10,
    parameter int COMBO_STEP = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic [3:0]  i_lane_en,
    input  logic [7:0]  i_state,
    input  logic [3:0]  i_btn,
    output logic [3:0]  o_hit,
    output logic [3:0]  o_miss,
    output logic [3:0]  o_ghost,
    output logic [15:0] o_score,
    output logic [7:0]  o_combo,
    output logic [7:0]  o_max_combo,
    output logic [2:0]  o_mult
);
    localparam int NUM_LANES = 4;
`ifdef NOTE_JUDGE_GHOST_PENALTY_EN
    localparam bit GHOST_EN = 1'b1;
`else
    localparam bit GHOST_EN = 1'b0;
`endif

    logic [NUM_LANES-1:0] s1, s2, s3, press;
    logic [NUM_LANES-1:0] hit_c, miss_c, ghost_c;
    logic [2:0]           h_cnt;
    logic [7:0]           combo_q, combo_nxt;
    logic [8:0]           combo_sum;
    logic [18:0]          sum19;
    logic [15:0]          score_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= i_btn;
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign press = s2 & ~s3;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        note_lane #(.GHOST_EN(GHOST_EN)) u_lane (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .en    (i_lane_en[g]),
            .st    (i_state[2*g +: 2]),
            .stb   (i_ani_stb),
            .press (press[g]),
            .hit   (hit_c[g]),
            .miss  (miss_c[g]),
            .ghost (ghost_c[g])
        );
    end

    always_comb begin
        h_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) h_cnt = h_cnt + {2'b0, hit_c[i]};
    end

    assign combo_q = o_combo / 8'(COMBO_STEP);
    assign o_mult  = (combo_q >= 8'd3) ? 3'd4 : 3'd1 + combo_q[2:0];

    // points use the multiplier from the combo before this update
    assign sum19     = {3'b0, o_score} + 19'(h_cnt) * 19'(HIT_PTS) * 19'(o_mult);
    assign score_nxt = (|sum19[18:16]) ? 16'hFFFF : sum19[15:0];
    assign combo_sum = {1'b0, o_combo} + 9'(h_cnt);
    assign combo_nxt = (|miss_c || |ghost_c) ? 8'd0 :
                       combo_sum[8]          ? 8'hFF : combo_sum[7:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hit       <= '0;
            o_miss      <= '0;
            o_ghost     <= '0;
            o_score     <= '0;
            o_combo     <= '0;
            o_max_combo <= '0;
        end else begin
            o_hit   <= hit_c;
            o_miss  <= miss_c;
            o_ghost <= ghost_c;
            o_score <= score_nxt;
            o_combo <= combo_nxt;
            if (combo_nxt > o_max_combo) o_max_combo <= combo_nxt;
        end
    end
endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge: hits, misses, races, lane disable, ghost and saturation.
module tb_note_judge;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ani_stb;
    logic [3:0]  i_lane_en;
    logic [7:0]  i_state;
    logic [3:0]  i_btn;
    logic [3:0]  o_hit, o_miss, o_ghost;
    logic [15:0] o_score;
    logic [7:0]  o_combo, o_max_combo;
    logic [2:0]  o_mult;

    int n_cmp = 0;
    int n_err = 0;
    int m_score, m_combo, m_max;

    note_judge dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_lane_en(i_lane_en),
        .i_state(i_state), .i_btn(i_btn), .o_hit(o_hit), .o_miss(o_miss),
        .o_ghost(o_ghost), .o_score(o_score), .o_combo(o_combo),
        .o_max_combo(o_max_combo), .o_mult(o_mult)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lane_st(input logic [3:0] m, input logic [1:0] v);
        logic [7:0] r = '0;
        for (int n = 0; n < 4; n++) if (m[n]) r[2*n +: 2] = v;
        return r;
    endfunction

    task automatic do_reset();
        i_rst = 1'b1; i_ani_stb = 1'b0; i_lane_en = 4'hF; i_state = '0; i_btn = '0;
        tick(); tick();
        i_rst = 1'b0;
        m_score = 0; m_combo = 0; m_max = 0;
    endtask

    // zone -> press -> hit pulse -> release -> bottom, updating the reference counts
    task automatic hit_round(input logic [3:0] mask);
        int pop, m;
        pop = $countones(mask);
        i_state = lane_st(mask, 2'b01); tick();
        i_btn = mask; tick(); tick(); tick();
        chk("round_hit", 32'(o_hit), 32'(mask));
        m = 1 + ((m_combo / 10 > 3) ? 3 : m_combo / 10);
        m_score = m_score + pop * 10 * m;
        if (m_score > 65535) m_score = 65535;
        m_combo = m_combo + pop;
        if (m_combo > 255) m_combo = 255;
        if (m_combo > m_max) m_max = m_combo;
        i_btn = '0; i_state = '0; tick();
        i_state = lane_st(mask, 2'b10); i_ani_stb = 1'b1; tick();
        i_ani_stb = 1'b0; i_state = '0; tick();
    endtask

    initial begin
        int hits;
        do_reset();
        chk("rst_hit", 32'(o_hit), 0);
        chk("rst_miss", 32'(o_miss), 0);
        chk("rst_ghost", 32'(o_ghost), 0);
        chk("rst_score", 32'(o_score), 0);
        chk("rst_combo", 32'(o_combo), 0);
        chk("rst_max", 32'(o_max_combo), 0);
        chk("rst_mult", 32'(o_mult), 1);

        // single hit, button held afterwards
        i_state = lane_st(4'b0001, 2'b01);
        repeat (3) tick();
        i_btn = 4'b0001; tick(); tick();
        chk("hit_k1", 32'(o_hit), 0);
        tick();
        chk("hit_k2", 32'(o_hit), 32'b0001);
        chk("hit_score", 32'(o_score), 10);
        chk("hit_combo", 32'(o_combo), 1);
        chk("hit_mult", 32'(o_mult), 1);
        hits = 0;
        repeat (12) begin tick(); if (o_hit != 0) hits++; end
        chk("hold_norepeat", 32'(hits), 0);

        // hit then bottom: no miss
        i_btn = '0; i_state = '0; tick();
        i_state = lane_st(4'b0001, 2'b10); i_ani_stb = 1'b1; tick();
        chk("hitbot_miss", 32'(o_miss), 0);
        i_ani_stb = 1'b0; i_state = '0; tick();
        chk("hitbot_score", 32'(o_score), 10);

        // unhit note
        i_state = lane_st(4'b0001, 2'b01); tick();
        i_state = '0; tick();
        i_state = lane_st(4'b0001, 2'b10); i_ani_stb = 1'b1; tick();
        chk("unhit_miss", 32'(o_miss), 32'b0001);
        chk("unhit_combo", 32'(o_combo), 0);
        chk("unhit_score", 32'(o_score), 10);
        chk("unhit_max", 32'(o_max_combo), 1);
        i_ani_stb = 1'b0; i_state = '0; tick();
        chk("unhit_once", 32'(o_miss), 0);

        // multiplier step
        do_reset();
        repeat (10) hit_round(4'b0001);
        chk("ten_score", 32'(o_score), 100);
        chk("ten_combo", 32'(o_combo), 10);
        chk("ten_mult", 32'(o_mult), 2);
        hit_round(4'b1111);
        chk("quad_score", 32'(o_score), 180);
        chk("quad_combo", 32'(o_combo), 14);
        chk("quad_max", 32'(o_max_combo), 14);

        // lane-1 hit and lane-2 bottom miss on the same edge
        i_state = lane_st(4'b0010, 2'b01); tick();
        i_btn = 4'b0010; tick(); tick();
        i_state = lane_st(4'b0010, 2'b01) | lane_st(4'b0100, 2'b10); i_ani_stb = 1'b1; tick();
        chk("race_hit", 32'(o_hit), 32'b0010);
        chk("race_miss", 32'(o_miss), 32'b0100);
        chk("race_combo", 32'(o_combo), 0);
        chk("race_score", 32'(o_score), 200);
        chk("race_max", 32'(o_max_combo), 14);
        i_ani_stb = 1'b0; i_btn = '0; i_state = '0; tick();
        i_state = lane_st(4'b0010, 2'b10); i_ani_stb = 1'b1; tick();
        chk("race_clean", 32'(o_miss), 0);
        i_ani_stb = 1'b0; i_state = '0; tick();

        // press on the same cycle the zone drops back to 00
        i_state = lane_st(4'b0100, 2'b01); tick();
        i_btn = 4'b0100; tick(); tick();
        i_state = '0; tick();
        chk("zexit_hit", 32'(o_hit), 32'b0100);
        chk("zexit_score", 32'(o_score), 210);
        chk("zexit_combo", 32'(o_combo), 1);
        i_btn = '0; tick();
        i_state = lane_st(4'b0100, 2'b10); i_ani_stb = 1'b1; tick();
        chk("zexit_nomiss", 32'(o_miss), 0);
        i_ani_stb = 1'b0; i_state = '0; tick();

        // disabled lane ignores presses and bottoms
        i_lane_en = 4'b1110;
        i_state = lane_st(4'b0001, 2'b01); tick();
        i_btn = 4'b0001; tick(); tick(); tick();
        chk("dis_hit", 32'(o_hit), 0);
        i_btn = '0; i_state = lane_st(4'b0001, 2'b10); i_ani_stb = 1'b1; tick();
        chk("dis_miss", 32'(o_miss), 0);
        chk("dis_score", 32'(o_score), 210);
        chk("dis_combo", 32'(o_combo), 1);
        i_ani_stb = 1'b0; i_state = '0; i_lane_en = 4'hF; tick(); tick();

        // stray press on idle lane 3
        do_reset();
        repeat (5) hit_round(4'b0001);
        chk("pre_ghost_combo", 32'(o_combo), 5);
        i_btn = 4'b1000; tick(); tick(); tick();
`ifdef NOTE_JUDGE_GHOST_PENALTY_EN
        chk("ghost_pulse", 32'(o_ghost), 32'b1000);
        chk("ghost_combo", 32'(o_combo), 0);
        m_combo = 0;
`else
        chk("ghost_pulse", 32'(o_ghost), 0);
        chk("ghost_combo", 32'(o_combo), 5);
`endif
        chk("ghost_score", 32'(o_score), 50);
        chk("ghost_hit", 32'(o_hit), 0);
        tick();
        chk("ghost_once", 32'(o_ghost), 0);
        i_btn = '0; tick(); tick(); tick();

        // drive score and combo into saturation
        for (int r = 0; r < 1000 && m_score != 65535; r++) hit_round(4'b1111);
        hit_round(4'b1111);
        chk("sat_score", 32'(o_score), 65535);
        chk("sat_combo", 32'(o_combo), 255);
        chk("sat_max", 32'(o_max_combo), 255);
        chk("sat_mult", 32'(o_mult), 4);
        chk("sat_model_score", 32'(o_score), 32'(m_score));

        // reset mid-operation with a press in flight
        i_state = lane_st(4'b0001, 2'b01); tick();
        i_btn = 4'b0001; tick();
        i_rst = 1'b1; i_btn = '0; i_state = '0; tick();
        i_rst = 1'b0;
        chk("mid_rst_score", 32'(o_score), 0);
        chk("mid_rst_combo", 32'(o_combo), 0);
        chk("mid_rst_mult", 32'(o_mult), 1);
        hits = 0;
        repeat (4) begin tick(); if (o_hit != 0) hits++; end
        chk("mid_rst_nohit", 32'(hits), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/note_judge.md
# note_judge

Per-lane hit judge and scorer for the four-lane falling-note display. It sits directly downstream of the four note/square animators: it consumes each animator's 2-bit zone/bottom state together with the player's raw push buttons. It produces one-cycle hit/miss pulses, a running score, a combo count and a multiplier for the HUD/score renderer.

## Interface
- HIT_PTS, 10 — base points per hit before multiplier
- COMBO_STEP, 10 — combo hits per multiplier step
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_ani_stb  in  1  animation strobe; the same strobe that drives the note animators
- i_lane_en  in  4  per-lane note enable, mirrors each animator's enable; bit 3 = leftmost lane
- i_state  in  8  lane n state at bits [2n+1:2n]; 2'b01 = note in push zone, 2'b10 = note reached bottom, 2'b00 = neither
- i_btn  in  4  raw, asynchronous push buttons, one per lane
- o_hit  out  4  one-cycle pulse per lane on a judged hit
- o_miss  out  4  one-cycle pulse per lane on a judged miss
- o_ghost  out  4  one-cycle pulse on a press with no note in the zone; constant 0 unless the macro is defined
- o_score  out  16  accumulated score, saturating
- o_combo  out  8  current consecutive-hit count, saturating at 255
- o_max_combo  out  8  highest o_combo since reset
- o_mult  out  3  current multiplier, 1..4

## Operation
- **Button input path:** 2-FF synchronizer, then a third register. Press event = s2 & ~s3, asserted once per rising edge. Holding a button does not repeat the event.
- **Per-lane FSM.** States are IDLE, ZONE and HIT.
  - IDLE -> ZONE when the lane state is 01.
  - ZONE -> HIT on a press event; pulse o_hit.
  - ZONE -> IDLE when the lane state returns to 00 with no press. No pulse; the note is still pending.
  - HIT -> IDLE on a bottom event. No miss is reported.
  - HIT with state 00 stays in HIT.
- **Bottom event:** lane state == 10 in a cycle with i_ani_stb = 1.
  - A bottom event in IDLE or ZONE pulses o_miss and moves the lane to IDLE.
- **Lane enable:** i_lane_en[n] = 0 forces lane n to IDLE.
  - No hit or miss is reported for that lane.
  - Press events on that lane are ignored.
- **Multiplier:** o_mult = 1 + min(o_combo / COMBO_STEP, 3), computed combinationally from the registered combo.
- **Score update** per cycle, with H = number of o_hit bits set:
  - score += H × HIT_PTS × o_mult, using the pre-update multiplier.
  - The sum is computed in 19 bits and clamps to 0xFFFF.
- **Combo update:**
  - Any miss in the cycle sets combo to 0. Hits in that same cycle still score.
  - Otherwise combo += H, saturating at 255.
- **Max combo:** o_max_combo is updated to the new combo whenever the new combo is larger.
- **Simultaneous events:**
  - A press and a ZONE->IDLE transition in the same cycle: the press wins (hit).
  - A press and a bottom event in ZONE in the same cycle: the bottom event wins (miss).

## Timing
- Reset: all lanes IDLE; synchronizer registers 0; o_hit, o_miss, o_ghost, o_score, o_combo and o_max_combo all 0; o_mult = 1.
- Reset mid-operation clears everything on the next edge. A press already in the synchronizer is discarded.
- Press latency: the button is first sampled high at edge k; the FSM moves to HIT and o_hit is registered at edge k+2.
- Score, combo and max combo update at the same edge as the corresponding o_hit/o_miss. There is no further pipeline.
- Pulses last exactly one i_clk cycle.
- i_state is sampled every cycle for zone checks. Bottom events are qualified only by i_ani_stb.

## Configuration
- NOTE_JUDGE_GHOST_PENALTY_EN
  - **Defined:** a press event in a lane that is in IDLE or HIT (while enabled) pulses o_ghost[n] and sets combo to 0. It does not alter score or FSM state.
  - **Undefined:** such presses are ignored and o_ghost is tied to 0.

## Test plan
- **Single hit:** lane 0 state 01 for 20 cycles; press i_btn[0] once. Required: o_hit = 4'b0001 exactly once at edge k+2; score = 10; combo = 1; mult = 1.
- **Hit then bottom:** after the hit above, drive state 00 and then 10 with i_ani_stb. Required: no o_miss; lane returns to IDLE; score stays 10.
- **Unhit note:** state 01, then 00, then 10 with a strobe, no press. Required: o_miss = 4'b0001 once; combo = 0; score unchanged.
- **Multiplier step and saturation:** 10 sequential hits, then a simultaneous 4-lane hit. Required: score after the 10 hits = 100; the 4-lane hit adds 4 × 10 × 2 = 80 (score 180, combo 14). Preloaded near the top, score clamps at 65535.
- **Miss beats hit:** lane 1 hit and lane 2 bottom-miss in the same cycle. Required: combo = 0; the lane-1 points are still added; max combo retains its prior value.
- **Ghost press** (macro defined): combo = 5; press lane 3 while it is IDLE. Required: o_ghost = 4'b1000 once; combo = 0; score unchanged. With the macro undefined: no change.
